// File: rtl/wb_data_ram.sv
// Wishbone classic slave fronting a 32-bit word RAM with big-endian byte lanes.
// A fixed number of wait states precede a one-cycle ack, or an err for addresses beyond the array.
module wb_data_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  // Handshake: a request is taken when cyc & stb are high in IDLE; ack/err is
  // high for exactly the RESP cycle; dropping cyc during WAIT abandons it.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] adr_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic        ack_q, ack_d, err_q, err_d;
  logic [31:0] rdat_q;
  logic        latch, go_resp;
  logic [29:0] req_wadr;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic        req_oor;
  logic        mem_we, mem_re;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [31:0] mem [DEPTH];
  logic        unused_adr_lsb;

  assign unused_adr_lsb = ^wb_adr_i[1:0];

  // With no wait states RESP is entered on the accepting edge itself, so the
  // request must come straight off the bus rather than from the latched copy.
  always_comb begin
    req_wadr = adr_q;
    req_we   = we_q;
    req_sel  = sel_q;
    req_dat  = dat_q;
    if (state_q == S_IDLE) begin
      req_wadr = wb_adr_i[31:2];
      req_we   = wb_we_i;
      req_sel  = wb_sel_i;
      req_dat  = wb_dat_i;
    end
  end

  assign req_oor = (req_wadr >> ADDR_WIDTH) != 30'd0;
  assign req_idx = req_wadr[ADDR_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    go_resp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          latch = 1'b1;
          cnt_d = WS;
          if (WS == 4'd0) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we = go_resp && req_we && !req_oor;
  assign mem_re = go_resp && !req_we && !req_oor;
  assign ack_d  = go_resp && !req_oor;
  assign err_d  = go_resp && req_oor;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (mem_re) rdat_q <= mem[req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && latch) begin
      adr_q <= wb_adr_i[31:2];
      we_q  <= wb_we_i;
      sel_q <= wb_sel_i;
      dat_q <= wb_dat_i;
    end
  end

  // sel[3] steers bits [31:24], the lowest byte address in big-endian order.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) mem[req_idx][8*b +: 8] <= req_dat[8*b +: 8];
      end
    end
  end

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_data_ram.sv
// Bench for wb_data_ram: four instances with WAIT_STATES 0..3, a directed vector table,
// hand-built multi-cycle corner sequences and randomized traffic against a word/byte-mask model.
module tb_wb_data_ram;

  localparam int NI = 4;
  localparam int NV = 18;

  logic        clk;
  logic        rst   [NI];
  logic        cyc   [NI];
  logic        stb   [NI];
  logic        we    [NI];
  logic [31:0] adr   [NI];
  logic [3:0]  sel   [NI];
  logic [31:0] dat_i [NI];
  logic [31:0] dat_o [NI];
  logic        ack   [NI];
  logic        err   [NI];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(g)) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .wb_cyc_i (cyc[g]),
      .wb_stb_i (stb[g]),
      .wb_we_i  (we[g]),
      .wb_adr_i (adr[g]),
      .wb_sel_i (sel[g]),
      .wb_dat_i (dat_i[g]),
      .wb_dat_o (dat_o[g]),
      .wb_ack_o (ack[g]),
      .wb_err_o (err[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: memory as words with per-byte known flags, plus last read data.
  logic [31:0] m_mem [NI][1024];
  logic [3:0]  m_val [NI][1024];
  logic [31:0] m_dat [NI];
  bit          m_dat_known [NI];

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h expected=%h", name, i, act, exp);
    end
  endtask

  task automatic model(input int i, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output bit e_err);
    logic [9:0]  widx;
    logic [31:0] mask;
    widx  = a[11:2];
    e_err = (a >> 2) >= 32'd1024;
    if (!e_err) begin
      if (w) begin
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        m_mem[i][widx] = (m_mem[i][widx] & ~mask) | (d & mask);
        m_val[i][widx] = m_val[i][widx] | s;
      end else begin
        m_dat[i]       = m_mem[i][widx];
        m_dat_known[i] = (m_val[i][widx] == 4'hF);
      end
    end
  endtask

  task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output bit g_ack, output bit g_err, output logic [31:0] g_dat);
    int lat;
    bit done;
    @(negedge clk);
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; sel[i] = s; dat_i[i] = d;
    lat = 0; done = 1'b0; g_ack = 1'b0; g_err = 1'b0; g_dat = 32'h0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ack[i] || err[i]) begin
        done  = 1'b1;
        g_ack = ack[i];
        g_err = err[i];
        g_dat = dat_o[i];
        cyc[i] = 1'b0; stb[i] = 1'b0;
      end
    end
    if (!done) begin
      cyc[i] = 1'b0; stb[i] = 1'b0;
      checks++; failures++;
      $display("FAIL timeout inst%0d actual=no_response expected=response", i);
    end else begin
      check("latency", i, lat, i + 1);
      check("ack_xor_err", i, 32'(g_ack ^ g_err), 1);
      @(negedge clk);
      check("single_cycle", i, {ack[i], err[i]}, 0);
    end
  endtask

  task automatic run_chk(input int i, input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bit e_err, g_ack, g_err;
    logic [31:0] g_dat;
    model(i, w, a, s, d, e_err);
    txn(i, w, a, s, d, g_ack, g_err, g_dat);
    check("ack", i, 32'(g_ack), 32'(!e_err));
    check("err", i, 32'(g_err), 32'(e_err));
    if (m_dat_known[i]) check("dat_o", i, g_dat, m_dat[i]);
  endtask

  task automatic expect_quiet(input int i, input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(name, i, {ack[i], err[i]}, 0);
    end
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    bit          exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    bit e_err, g_ack, g_err;
    logic [31:0] g_dat, a;

    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h11223344, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 32'h0000_0020, 4'h4, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0000_0000, 1'b0, 32'h11BB3344};
    vecs[5]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFEF00D, 1'b0, 32'h11BB3344};
    vecs[6]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h12345678, 1'b1, 32'h11BB3344};
    vecs[7]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 32'h0000_0024, 4'hF, 32'h01020304, 1'b0, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 32'h0000_0024, 4'h0, 32'hFFFFFFFF, 1'b0, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 32'h0000_0024, 4'h1, 32'h0000_0000, 1'b0, 32'h01020304};
    vecs[11] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0000_0000, 1'b1, 32'h01020304};
    vecs[12] = '{1'b1, 32'h0000_0024, 4'h8, 32'hAA000000, 1'b0, 32'h01020304};
    vecs[13] = '{1'b0, 32'h0000_0027, 4'hF, 32'h0000_0000, 1'b0, 32'hAA020304};
    vecs[14] = '{1'b1, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000, 1'b1, 32'hAA020304};
    vecs[15] = '{1'b1, 32'h0000_002C, 4'h3, 32'h0000BEEF, 1'b0, 32'hAA020304};
    vecs[16] = '{1'b1, 32'h0000_002C, 4'hC, 32'hDEAD0000, 1'b0, 32'hAA020304};
    vecs[17] = '{1'b0, 32'h0000_002C, 4'h0, 32'h0000_0000, 1'b0, 32'hDEADBEEF};

    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      adr[i] = 32'h0; sel[i] = 4'h0; dat_i[i] = 32'h0;
      m_dat[i] = 32'h0; m_dat_known[i] = 1'b1;
      for (int w = 0; w < 1024; w++) m_val[i][w] = 4'h0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_ack", i, 32'(ack[i]), 0);
      check("rst_err", i, 32'(err[i]), 0);
      check("rst_dat", i, dat_o[i], 32'h0);
      rst[i] = 1'b0;
    end

    // Directed table on the one-wait-state instance
    for (int k = 0; k < NV; k++) begin
      model(1, vecs[k].w, vecs[k].a, vecs[k].s, vecs[k].d, e_err);
      txn(1, vecs[k].w, vecs[k].a, vecs[k].s, vecs[k].d, g_ack, g_err, g_dat);
      check($sformatf("vec%0d_ack", k), 1, 32'(g_ack), 32'(!vecs[k].exp_err));
      check($sformatf("vec%0d_err", k), 1, 32'(g_err), 32'(vecs[k].exp_err));
      check($sformatf("vec%0d_dout", k), 1, g_dat, vecs[k].exp_dout);
    end

    // Requests while reset is held are ignored
    @(negedge clk);
    rst[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h10; sel[1] = 4'hF; dat_i[1] = 32'h0;
    expect_quiet(1, 3, "rst_held_quiet");
    rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    check("rst_held_dat", 1, dat_o[1], 32'h0);
    m_dat[1] = 32'h0; m_dat_known[1] = 1'b1;
    expect_quiet(1, 3, "rst_release_quiet");
    run_chk(1, 1'b0, 32'h10, 4'hF, 32'h0);

    // Zero wait states, strobe held: acks on cycles 1, 3, 5
    run_chk(0, 1'b1, 32'h4, 4'hF, 32'h600DF00D);
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h4; sel[0] = 4'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ack_c%0d", k), 0, 32'(ack[0]), 32'(k % 2));
      check($sformatf("b2b_err_c%0d", k), 0, 32'(err[0]), 0);
      if (k % 2 == 1) check($sformatf("b2b_dat_c%0d", k), 0, dat_o[0], 32'h600DF00D);
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    model(0, 1'b0, 32'h4, 4'h0, 32'h0, e_err);

    // Abort with three wait states
    run_chk(3, 1'b1, 32'h8, 4'hF, 32'h0BADCAFE);
    @(negedge clk);
    cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; adr[3] = 32'h8; sel[3] = 4'hF; dat_i[3] = 32'h55;
    @(negedge clk);
    cyc[3] = 1'b0; stb[3] = 1'b0;
    expect_quiet(3, 8, "abort_quiet");
    run_chk(3, 1'b0, 32'h8, 4'hF, 32'h0);

    // Reset pulse during WAIT of a write, two wait states
    run_chk(2, 1'b1, 32'h30, 4'hF, 32'h13579BDF);
    run_chk(2, 1'b0, 32'h30, 4'hF, 32'h0);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h30; sel[2] = 4'hF; dat_i[2] = 32'h2468ACE0;
    @(negedge clk);
    check("midrst_wait_quiet", 2, {ack[2], err[2]}, 0);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    check("midrst_dat", 2, dat_o[2], 32'h0);
    m_dat[2] = 32'h0; m_dat_known[2] = 1'b1;
    expect_quiet(2, 8, "midrst_quiet");
    run_chk(2, 1'b0, 32'h30, 4'hF, 32'h0);

    // Randomized traffic on every instance
    for (int i = 0; i < NI; i++) begin
      for (int w = 0; w < 16; w++) run_chk(i, 1'b1, 32'(w * 4), 4'hF, $urandom);
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
        else a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        run_chk(i, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_data_ram.md
WB_DATA_RAM -- requirements
Module: wb_data_ram

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 10: word-address width, so depth is 2^ADDR_WIDTH 32-bit words (4 KiB by default).
REQ-002 SHALL provide parameter WAIT_STATES, default 1, legal range 0..15: added cycles before acknowledge.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high (`RstEnable` = 1'b1).
REQ-005 wb_cyc_i  input  1  bus cycle active.
REQ-006 wb_stb_i  input  1  strobe, qualifies a transfer.
REQ-007 wb_we_i  input  1  1 = write, 0 = read.
REQ-008 wb_adr_i  input  32  byte address; bits [1:0] ignored.
REQ-009 wb_sel_i  input  4  byte lanes; sel[3] = data bits [31:24] = lowest byte address (big-endian, MIPS).
REQ-010 wb_dat_i  input  32  write data.
REQ-011 wb_dat_o  output  32  registered read data.
REQ-012 wb_ack_o  output  1  single-cycle acknowledge.
REQ-013 wb_err_o  output  1  single-cycle error, in place of ack.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 In IDLE, on wb_cyc_i & wb_stb_i, SHALL latch adr, we, sel and dat_i.
REQ-016 On that same IDLE edge, SHALL load a wait counter with WAIT_STATES.
REQ-017 From IDLE, SHALL go to RESP if WAIT_STATES = 0, else to WAIT.
REQ-018 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-019 In WAIT, if wb_cyc_i = 0 on a rising edge, SHALL abort to IDLE: no memory write, no ack, no err.
REQ-020 The request is latched at edge E0. The edge entering RESP (E0 + WAIT_STATES) SHALL:
- write memory if the latched we = 1;
- load wb_dat_o with the addressed word if the latched we = 0.
REQ-021 wb_ack_o (or wb_err_o) SHALL be high for exactly the one cycle spent in RESP. That is WAIT_STATES+1 cycles after the strobe is sampled.
REQ-022 RESP SHALL go to IDLE unconditionally.
- The minimum spacing between acknowledges is WAIT_STATES+2 cycles.
- A strobe still high in the cycle after ack SHALL be treated as a new request.
REQ-023 A write SHALL update only the byte lanes whose sel bit is 1; other bytes keep their old value.
REQ-024 A read SHALL return all 32 bits regardless of sel.
REQ-025 If latched adr[31:ADDR_WIDTH+2] is nonzero, SHALL assert wb_err_o in RESP instead of wb_ack_o, with no write and wb_dat_o unchanged.
REQ-026 A write with sel = 4'b0000 SHALL be acknowledged and SHALL leave memory unchanged.
REQ-027 wb_dat_o SHALL change only on an in-range read entering RESP; it holds its value otherwise.
REQ-028 wb_ack_o and wb_err_o SHALL never both be high.
REQ-029 wb_ack_o and wb_err_o SHALL never be high outside RESP.
REQ-030 Inputs SHALL NOT be sampled in WAIT or RESP, except wb_cyc_i for abort.

Reset
REQ-031 While rst = 1 at a rising edge, SHALL force: state = IDLE, counter = 0, wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 32'h0.
REQ-032 Reset in WAIT or RESP SHALL cancel any pending write, and no ack SHALL follow.
REQ-033 Memory contents SHALL NOT be cleared by reset; after power-up they are undefined.
REQ-034 Requests presented while rst = 1 SHALL be ignored.

Verification
REQ-035 Write then read, WAIT_STATES = 1:
- stimulus: write adr 0x0000_0010, sel 4'hF, dat 0xDEADBEEF; then read 0x10;
- response: each ack exactly 2 cycles after stb sampled; read returns 0xDEADBEEF.
REQ-036 Byte lanes:
- stimulus: preload 0x11223344 at 0x20; write sel 4'b0100, dat 0xAABBCCDD; read 0x20;
- response: read returns 0x11BB3344.
REQ-037 Zero wait states, WAIT_STATES = 0:
- stimulus: stb held high for a read at 0x4;
- response: ack in cycles 1, 3, 5 after the first sample (one IDLE gap between acks).
REQ-038 Out of range, ADDR_WIDTH = 10:
- stimulus: write adr 0x0000_1000;
- response: wb_err_o for 1 cycle, no ack; read of 0x0 returns its prior value.
REQ-039 Abort, WAIT_STATES = 3:
- stimulus: write 0x55 to 0x8; drop wb_cyc_i one cycle after the strobe is sampled;
- response: no ack; read of 0x8 returns its old value.
REQ-040 Reset mid-operation, WAIT_STATES = 2:
- stimulus: pulse rst one cycle while in WAIT on a write;
- response: ack never asserted; wb_dat_o = 0; target word unchanged; the next read completes normally.
